// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one 24-bit SPI master
// among N_REQ register-access clients, with done watchdog and idle gap.
module spi_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255,
  parameter int GAP     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_REQ-1:0]      req,
  input  logic [8*N_REQ-1:0]    req_addr,
  input  logic [16*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [23:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  m_start,
  output logic [7:0]            m_addr,
  output logic [15:0]           m_data,
  input  logic                  m_done,
  input  logic [23:0]           m_rdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WLOW  = 3'd2;
  localparam logic [2:0] S_WHIGH = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [2:0] S_AFTER = (GAP == 0) ? S_IDLE : S_GAP;

  logic [2:0]    state, state_n;
  logic [IW-1:0] last, idx, pick, cand;
  logic          pick_vld;
  logic [7:0]    pick_addr;
  logic [15:0]   pick_data;
  logic [TW-1:0] tcnt;
  logic [3:0]    gcnt;
  logic          in_wait, tmo, done_ok, fin;

  assign in_wait = (state == S_WLOW) || (state == S_WHIGH);
  assign tmo     = in_wait && (tcnt == TW'(TIMEOUT - 1));
  assign done_ok = (state == S_WHIGH) && m_done;
  assign fin     = done_ok || tmo;

  // scan requesters starting just past the last winner
  always_comb begin
    pick      = '0;
    pick_vld  = 1'b0;
    cand      = '0;
    pick_addr = '0;
    pick_data = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last) + k) % N_REQ);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i)) begin
        pick_addr = req_addr[8*i +: 8];
        pick_data = req_wdata[16*i +: 16];
      end
    end
  end

  // sequencing: grant, start, done low, done high (or watchdog), gap
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (pick_vld) state_n = S_START;
      S_START: state_n = S_WLOW;
      S_WLOW: begin
        if (tmo)          state_n = S_AFTER;
        else if (!m_done) state_n = S_WHIGH;
      end
      S_WHIGH: if (fin) state_n = S_AFTER;
      S_GAP:   if (int'(gcnt) >= GAP - 1) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // registered outputs, pointer and counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      last      <= IW'(N_REQ - 1);
      idx       <= '0;
      tcnt      <= '0;
      gcnt      <= '0;
      grant     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_addr    <= '0;
      m_data    <= '0;
    end else begin
      state     <= state_n;
      busy      <= (state_n != S_IDLE);
      grant     <= '0;
      rsp_valid <= '0;
      m_start   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant  <= N_REQ'(1) << pick;
            m_addr <= pick_addr;
            m_data <= pick_data;
            last   <= pick;
            idx    <= pick;
          end
        end
        S_START: begin
          m_start <= 1'b1;
          tcnt    <= '0;
        end
        S_WLOW, S_WHIGH: begin
          tcnt <= tcnt + 1'b1;
          if (fin) begin
            rsp_valid <= N_REQ'(1) << idx;
            rsp_err   <= !done_ok;
            rsp_data  <= done_ok ? m_rdata : 24'd0;
            gcnt      <= '0;
          end
        end
        S_GAP: gcnt <= gcnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed and randomized checks of the
// round-robin SPI request arbiter against a behavioural model.
module tb_spi_req_arbiter;

  localparam int N   = 4;
  localparam int TMO = 255;
  localparam int GP  = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req;
  logic [8*N-1:0]  req_addr;
  logic [16*N-1:0] req_wdata;
  logic [N-1:0]    grant;
  logic [N-1:0]    rsp_valid;
  logic [23:0]     rsp_data;
  logic            rsp_err;
  logic            busy;
  logic            m_start;
  logic [7:0]      m_addr;
  logic [15:0]     m_data;
  logic            m_done;
  logic [23:0]     m_rdata;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_last   = N - 1;
  int last_rsp = -100;
  int t_start  = 0;
  int cur      = 0;
  logic [7:0]  cur_a = '0;
  logic [15:0] cur_d = '0;
  int          mst_len   = 0;
  logic [23:0] mst_rdata = '0;

  spi_req_arbiter #(
    .N_REQ(N),
    .TIMEOUT(TMO),
    .GAP(GP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .req(req),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .grant(grant),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .busy(busy),
    .m_start(m_start),
    .m_addr(m_addr),
    .m_data(m_data),
    .m_done(m_done),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // SPI master: done drops one cycle after start, rises mst_len cycles later
  initial begin : master
    int ml;
    logic [23:0] md;
    m_done  = 1'b1;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_start === 1'b1 && mst_len >= 0) begin
        ml = mst_len;
        md = mst_rdata;
        @(posedge clk);
        #1 m_done = 1'b0;
        repeat (ml) @(posedge clk);
        #1 m_rdata = md;
        m_done = 1'b1;
      end
    end
  end

  initial begin : guard
    #1000000;
    $display("FAIL global_timeout: stuck at cycle %0d, limit 100000", cyc);
    $fatal(1, "bench stopped");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_slot(input int i, input logic [7:0] a,
                          input logic [15:0] d);
    req_addr[8*i +: 8]   = a;
    req_wdata[16*i +: 16] = d;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++)
      if (r[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_rspv"}, 32'(rsp_valid), 0);
    check({tag, "_rspd"}, 32'(rsp_data), 0);
    check({tag, "_err"}, 32'(rsp_err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_mstart"}, 32'(m_start), 0);
    check({tag, "_maddr"}, 32'(m_addr), 0);
    check({tag, "_mdata"}, 32'(m_data), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req    = '0;
    tick();
    tick();
    resetn   = 1'b1;
    m_last   = N - 1;
    last_rsp = -100;
    tick();
  endtask

  task automatic start_phase(input int who, input int exp_gt, input bit hold);
    int n;
    n = 0;
    cur   = who;
    cur_a = req_addr[8*who +: 8];
    cur_d = req_wdata[16*who +: 16];
    while (grant === '0 && n < 40) begin
      if (cyc == last_rsp + GP) check("busy_gap_low", 32'(busy), 0);
      tick();
      n++;
    end
    check("grant_seen", 32'(grant != '0), 1);
    check("grant_who", 32'(grant), 1 << who);
    if (exp_gt >= 0) check("grant_time", cyc, exp_gt);
    check("grant_addr", 32'(m_addr), 32'(cur_a));
    check("grant_data", 32'(m_data), 32'(cur_d));
    check("grant_mstart_low", 32'(m_start), 0);
    check("grant_busy", 32'(busy), 1);
    if (!hold) req[who] = 1'b0;
    m_last = who;
    tick();
    check("mstart_pulse", 32'(m_start), 1);
    check("grant_one_cycle", 32'(grant), 0);
    t_start = cyc;
  endtask

  task automatic finish_phase(input int len, input logic [23:0] rd);
    int n, starts, lat;
    bit err;
    n      = 0;
    starts = 0;
    err    = (len < 0) || (len + 2 > TMO);
    lat    = err ? TMO : len + 2;
    while (rsp_valid === '0 && n < TMO + 20) begin
      tick();
      n++;
      if (m_start === 1'b1) starts++;
    end
    check("rsp_seen", 32'(rsp_valid != '0), 1);
    check("rsp_who", 32'(rsp_valid), 1 << cur);
    check("rsp_latency", cyc - t_start, lat);
    check("rsp_data", 32'(rsp_data), err ? 0 : 32'(rd));
    check("rsp_err", 32'(rsp_err), 32'(err));
    check("rsp_mstart_once", starts, 0);
    check("rsp_maddr_held", 32'(m_addr), 32'(cur_a));
    check("rsp_mdata_held", 32'(m_data), 32'(cur_d));
    last_rsp = cyc;
    tick();
    check("rsp_one_cycle", 32'(rsp_valid), 0);
    check("rsp_err_held", 32'(rsp_err), 32'(err));
    check("rsp_data_held", 32'(rsp_data), err ? 0 : 32'(rd));
    check("gap_busy", 32'(busy), 1);
  endtask

  task automatic wait_mst_idle();
    int n;
    n = 0;
    while (m_done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("mst_idle", 32'(m_done), 1);
  endtask

  initial begin : main
    int t, ng, rc, who, len;
    logic [N-1:0] add;
    logic [23:0] rd;

    resetn    = 1'b1;
    req       = '0;
    req_addr  = '0;
    req_wdata = '0;
    #1 resetn = 1'b0;
    tick();
    tick();
    check_zero("reset");
    resetn = 1'b1;
    tick();
    check("idle_grant", 32'(grant), 0);
    check("idle_busy", 32'(busy), 0);

    // single request
    set_slot(0, 8'h5A, 16'hBEEF);
    req       = 4'b0001;
    mst_len   = 50;
    mst_rdata = 24'h123456;
    t = cyc;
    start_phase(0, t + 1, 1'b0);
    finish_phase(50, 24'h123456);

    // all four held from reset: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++)
      set_slot(i, 8'($urandom), 16'($urandom));
    req = '1;
    t = cyc;
    for (int r = 0; r < 5; r++) begin
      len = $urandom_range(3, 30);
      rd  = 24'($urandom);
      mst_len   = len;
      mst_rdata = rd;
      start_phase(r % N, (r == 0) ? t + 1 : last_rsp + GP + 1, 1'b1);
      if (r == 4) req = '0;
      finish_phase(len, rd);
    end

    // fairness: 2 just served, then 0 and 2 together
    req = 4'b0100;
    mst_len = 10; mst_rdata = 24'hA0A0A0;
    start_phase(2, last_rsp + GP + 1, 1'b0);
    finish_phase(10, 24'hA0A0A0);
    req = 4'b0101;
    mst_len = 12; mst_rdata = 24'h0B0B0B;
    start_phase(0, last_rsp + GP + 1, 1'b0);
    finish_phase(12, 24'h0B0B0B);
    mst_len = 7; mst_rdata = 24'h0C0C0C;
    start_phase(2, last_rsp + GP + 1, 1'b0);
    finish_phase(7, 24'h0C0C0C);

    // watchdog with done stuck high
    set_slot(3, 8'h33, 16'h3333);
    req = 4'b1000;
    mst_len = -1;
    start_phase(3, last_rsp + GP + 1, 1'b0);
    finish_phase(-1, 24'h0);
    tick();
    check("tmo_busy_low", 32'(busy), 0);
    tick();
    tick();
    check("tmo_still_idle", 32'(busy), 0);
    check("tmo_no_grant", 32'(grant), 0);

    // done rise coinciding with the watchdog, then one cycle too late
    set_slot(1, 8'h11, 16'h1111);
    req = 4'b0010;
    mst_len = TMO - 2; mst_rdata = 24'hC0FFEE;
    t = cyc;
    start_phase(1, t + 1, 1'b0);
    finish_phase(TMO - 2, 24'hC0FFEE);
    req = 4'b0010;
    mst_len = TMO - 1; mst_rdata = 24'hBADBAD;
    start_phase(1, last_rsp + GP + 1, 1'b0);
    finish_phase(TMO - 1, 24'hBADBAD);
    wait_mst_idle();

    // withdrawal of requester 1 while 0 is served
    tick();
    tick();
    set_slot(0, 8'h0F, 16'hF00F);
    req = 4'b0001;
    mst_len = 30; mst_rdata = 24'h777777;
    t = cyc;
    start_phase(0, t + 1, 1'b0);
    tick(); tick(); tick();
    req[1] = 1'b1;
    tick(); tick();
    req[1] = 1'b0;
    finish_phase(30, 24'h777777);
    ng = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (grant !== '0) ng++;
      if (cyc == last_rsp + GP) check("wd_busy_low", 32'(busy), 0);
    end
    check("wd_no_grant", ng, 0);
    check("wd_idle", 32'(busy), 0);

    // reset while waiting for done high
    set_slot(0, 8'h44, 16'h4444);
    req = 4'b0001;
    mst_len = 60; mst_rdata = 24'h999999;
    t = cyc;
    start_phase(0, t + 1, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("pre_rst_busy", 32'(busy), 1);
    resetn = 1'b0;
    #2;
    check_zero("midrst");
    rc = 0;
    tick();
    if (rsp_valid !== '0) rc++;
    tick();
    resetn   = 1'b1;
    m_last   = N - 1;
    last_rsp = -100;
    for (int i = 0; i < 200 && m_done !== 1'b1; i++) begin
      tick();
      if (rsp_valid !== '0) rc++;
    end
    tick();
    if (rsp_valid !== '0) rc++;
    check("midrst_no_rsp", rc, 0);
    check("midrst_idle", 32'(busy), 0);
    set_slot(0, 8'h01, 16'h0101);
    set_slot(1, 8'h02, 16'h0202);
    req = 4'b0011;
    mst_len = 9; mst_rdata = 24'h010101;
    t = cyc;
    start_phase(0, t + 1, 1'b0);
    finish_phase(9, 24'h010101);
    mst_len = 4; mst_rdata = 24'h020202;
    start_phase(1, last_rsp + GP + 1, 1'b0);
    finish_phase(4, 24'h020202);

    // randomized arrivals against the round-robin model
    for (int r = 0; r < 16; r++) begin
      add = N'($urandom) & ~req;
      if ((req | add) == '0) add[$urandom_range(0, N - 1)] = 1'b1;
      for (int i = 0; i < N; i++)
        if (add[i]) set_slot(i, 8'($urandom), 16'($urandom));
      req = req | add;
      who = rr_pick(req, m_last);
      len = $urandom_range(1, 60);
      rd  = 24'($urandom);
      mst_len   = len;
      mst_rdata = rd;
      start_phase(who, last_rsp + GP + 1, 1'b0);
      finish_phase(len, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 24-bit SPI master (8-bit addr + 16-bit data, start/done handshake) between N_REQ requesters.
- Latches the winner's frame and pulses the master start. It tracks the master done low→high cycle, then returns the 24-bit received word to the winner.
- Sits between register-access clients (config FSMs, CPU bridge) and the SPI master. It adds a done-watchdog and a minimum idle gap so CS returns high between frames.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 255, maximum clk cycles from start pulse to master done re-assertion before aborting (≥64).
- GAP, 2, idle clk cycles enforced after each transaction before the next grant (0..15).

Ports:
- clk  in  1  system clock (10 MHz, same as SPI master).
- resetn  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level; held until its grant bit.
- req_addr  in  8*N_REQ  packed addresses; requester i at [8i+7:8i].
- req_wdata  in  16*N_REQ  packed write data; requester i at [16i+15:16i].
- grant  out  N_REQ  one-hot, one-cycle acceptance pulse.
- rsp_valid  out  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
- rsp_data  out  24  received word; valid while rsp_valid is high, held until the next completion.
- rsp_err  out  1  high with rsp_valid when the transaction timed out.
- busy  out  1  high in any state other than IDLE.
- m_start  out  1  start pulse to the SPI master.
- m_addr  out  8  address to the master; stable from grant until completion.
- m_data  out  16  write data to the master; stable from grant until completion.
- m_done  in  1  master done: 1 when idle, 0 during a frame.
- m_rdata  in  24  master received word.

Behaviour:
- All outputs are registered. Reset values: grant, rsp_valid, m_start, busy and rsp_err are 0; rsp_data, m_addr and m_data are 0. The state is IDLE, the pointer is last=N_REQ-1 (requester 0 has first priority) and all counters are 0.
- IDLE, when req≠0: select the first set bit scanning last+1, last+2, … modulo N_REQ.
  - At the same edge: register grant[i]=1, m_addr/m_data from slot i, last←i, idx←i, and go to START.
- START: m_start=1 for exactly this one cycle. The timeout counter clears. Go to WAIT_LOW.
- WAIT_LOW: wait for m_done==0, then go to WAIT_HIGH.
- WAIT_HIGH: wait for m_done==1. At that edge:
  - rsp_data←m_rdata, rsp_valid[idx]=1 (one cycle), rsp_err=0.
  - Go to GAP.
- Timeout counter: increments every cycle in WAIT_LOW and WAIT_HIGH. When it reaches TIMEOUT:
  - rsp_valid[idx]=1, rsp_err=1, rsp_data←0.
  - Go to GAP.
  - A genuine m_done rise in the same cycle wins: normal completion, rsp_err=0.
- GAP: count GAP cycles (GAP=0 means zero cycles), then go to IDLE. A req seen in the last GAP cycle is not granted until IDLE evaluates it.
- Timing: req set at edge k in IDLE gives grant at k+1 and m_start at k+2. Completion comes one cycle after m_done is seen high.
- Requester rules:
  - A requester deasserting req before its grant is simply skipped.
  - req held after a grant is treated as a new request for the next round; it is served after the others due to rotation.
  - req_addr/req_wdata are sampled only in the grant cycle.
- rsp_err stays high until the next rsp_valid.
- busy is 0 only in IDLE.
- Reset mid-transaction: immediate return to the reset values, with no rsp_valid issued. m_start is forced low.

Test Plan:
- Single request: req=0001, addr=0x5A, wdata=0xBEEF; master model drops done 1 cycle after start and raises it 50 cycles later with m_rdata=0x123456 -> grant[0] 1 cycle after req, m_start 1 cycle later, m_addr=0x5A and m_data=0xBEEF held, rsp_valid[0] with rsp_data=0x123456, rsp_err=0.
- All four requesting simultaneously from reset, req held high -> grant order 0,1,2,3,0. Each next grant comes exactly GAP+1 cycles after the previous rsp_valid; exactly one m_start per transaction.
- Fairness: requester 2 just served and requests again with requester 0 -> requester 0 is granted before requester 2.
- Watchdog: m_done stuck high after start -> after TIMEOUT=255 counted cycles, rsp_valid[idx]=1, rsp_err=1, rsp_data=0, then GAP, then IDLE with busy=0.
- Reset asserted in WAIT_HIGH -> all outputs 0 and no rsp_valid. After release, requester 0 has priority regardless of prior history.
- Request withdrawal: req[1] pulsed and dropped while busy serving requester 0 -> requester 1 never granted; busy falls after GAP.
